// File: rtl/switch_pkg.sv
// Register map, egress format and FSM encodings shared by the switch host initiator.
// Pure declarations: no latency or flow-control behaviour lives here.
package switch_pkg;

    localparam logic [2:0] ADDR_CTRL         = 3'd0;
    localparam logic [2:0] ADDR_INGRESS_BASE = 3'd1;
    localparam logic [2:0] ADDR_EGRESS       = 3'd5;

    localparam int EGRESS_VALID_BIT = 31;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START_X,
        RUN,
        STOP,
        DRAIN
    } host_state_t;

    // Sub-phase inside DRAIN: read strobe on the bus, then the response cycle.
    typedef enum logic [1:0] {
        D_ISSUE,
        D_WAIT,
        D_CAP
    } drain_phase_t;

endpackage

// File: rtl/switch_host_master_desc_fifo.sv
// Synchronous descriptor FIFO: head valid combinationally, push/pop both take effect at the next edge.
// No internal backpressure; caller gates push with !full (or a same-cycle pop) and pop with !empty.
module host_desc_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 34
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= push_dat;
    end

    assign head  = mem[rp];
    assign full  = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/switch_host_master.sv
// Host register initiator for the switch: load descriptors, run for N cycles, stop, drain egress. Registered bus, 1-cycle accesses.
// Descriptor input backpressured only by FIFO full; optional SWITCH_HOST_MASTER_CHECK_EN adds sent/rcvd counters and mismatch.
module switch_host_master
    import switch_pkg::*;
#(
    parameter int NUM_PORTS    = 4,
    parameter int RUN_CYCLES_W = 16,
    parameter int MAX_DRAIN    = 64,
    parameter int DESC_DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [RUN_CYCLES_W-1:0]      run_cycles,
    input  logic                         desc_valid,
    output logic                         desc_ready,
    input  logic [$clog2(NUM_PORTS)-1:0] desc_port,
    input  logic [31:0]                  desc_data,
    output logic [2:0]                   av_address,
    output logic [31:0]                  av_writedata,
    output logic                         av_write,
    output logic                         av_read,
    output logic                         av_chipselect,
    input  logic [31:0]                  av_readdata,
    output logic                         rx_valid,
    output logic [31:0]                  rx_data,
    output logic                         busy,
    output logic                         done
`ifdef SWITCH_HOST_MASTER_CHECK_EN
   ,output logic [15:0]                  sent_cnt,
    output logic [15:0]                  rcvd_cnt,
    output logic                         mismatch
`endif
);

    localparam int PW  = $clog2(NUM_PORTS);
    localparam int RDW = $clog2(MAX_DRAIN + 1);
    localparam int CW  = $clog2(DESC_DEPTH) + 1;

    host_state_t            st, st_nxt;
    drain_phase_t           ph;
    logic [RUN_CYCLES_W-1:0] run_cnt;
    logic [RDW-1:0]         rd_cnt;

    logic [PW-1:0]  head_port;
    logic [31:0]    head_data;
    logic           fifo_full, fifo_empty, pop;
    logic [CW-1:0]  fifo_count;

    logic        av_write_n, av_read_n, rx_valid_n, done_n;
    logic [2:0]  av_address_n;
    logic [31:0] av_writedata_n, rx_data_n;

    logic start_ok, cap_more, drain_end;

    assign start_ok   = (st == IDLE) && start;
    assign pop        = (st == LOAD) && !fifo_empty;
    assign desc_ready = !fifo_full || pop;
    assign busy       = (st != IDLE);
    assign cap_more   = av_readdata[EGRESS_VALID_BIT] && (rd_cnt != RDW'(MAX_DRAIN));
    assign drain_end  = (st == DRAIN) && (ph == D_CAP) && !cap_more;

    host_desc_fifo #(
        .DEPTH (DESC_DEPTH),
        .W     (PW + 32)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (desc_valid && desc_ready),
        .push_dat ({desc_port, desc_data}),
        .pop      (pop),
        .head     ({head_port, head_data}),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) st <= IDLE;
        else          st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:    if (start) st_nxt = (fifo_count == '0) ? START_X : LOAD;
            LOAD:    if (fifo_empty) st_nxt = START_X;
            START_X: st_nxt = RUN;
            RUN:     if (run_cnt == '0) st_nxt = STOP;
            STOP:    st_nxt = DRAIN;
            DRAIN:   if (drain_end) st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    always_comb begin
        av_write_n     = 1'b0;
        av_read_n      = 1'b0;
        av_address_n   = '0;
        av_writedata_n = '0;
        rx_valid_n     = 1'b0;
        rx_data_n      = rx_data;
        done_n         = drain_end;
        case (st)
            LOAD: if (!fifo_empty) begin
                av_write_n     = 1'b1;
                av_address_n   = ADDR_INGRESS_BASE + 3'(head_port);
                av_writedata_n = head_data;
            end
            START_X: begin
                av_write_n     = 1'b1;
                av_address_n   = ADDR_CTRL;
                av_writedata_n = 32'd1;
            end
            STOP: begin
                av_write_n     = 1'b1;
                av_address_n   = ADDR_CTRL;
            end
            DRAIN: begin
                if (ph == D_CAP && av_readdata[EGRESS_VALID_BIT]) begin
                    rx_valid_n = 1'b1;
                    rx_data_n  = {1'b0, av_readdata[30:0]};
                end
                if (ph == D_ISSUE || (ph == D_CAP && cap_more)) begin
                    av_read_n    = 1'b1;
                    av_address_n = ADDR_EGRESS;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            av_write      <= 1'b0;
            av_read       <= 1'b0;
            av_chipselect <= 1'b0;
            av_address    <= '0;
            av_writedata  <= '0;
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            done          <= 1'b0;
        end else begin
            av_write      <= av_write_n;
            av_read       <= av_read_n;
            av_chipselect <= av_write_n || av_read_n;
            av_address    <= av_address_n;
            av_writedata  <= av_writedata_n;
            rx_valid      <= rx_valid_n;
            rx_data       <= rx_data_n;
            done          <= done_n;
        end
    end

    // Read response arrives one cycle after the strobe, so DRAIN cycles through issue/wait/capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_cnt <= '0;
            rd_cnt  <= '0;
            ph      <= D_ISSUE;
        end else begin
            if (start_ok)                      run_cnt <= run_cycles;
            else if (st == RUN && run_cnt != '0) run_cnt <= run_cnt - 1'b1;
            if (st == STOP) begin
                rd_cnt <= '0;
                ph     <= D_ISSUE;
            end else if (st == DRAIN) begin
                if (av_read_n) rd_cnt <= rd_cnt + 1'b1;
                ph <= (ph == D_WAIT) ? D_CAP : D_WAIT;
            end
        end
    end

`ifdef SWITCH_HOST_MASTER_CHECK_EN
    logic [15:0] sent_n, rcvd_n;

    always_comb begin
        sent_n = sent_cnt;
        rcvd_n = rcvd_cnt;
        if (pop && sent_cnt != 16'hFFFF)        sent_n = sent_cnt + 1'b1;
        if (rx_valid_n && rcvd_cnt != 16'hFFFF) rcvd_n = rcvd_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sent_cnt <= '0;
            rcvd_cnt <= '0;
            mismatch <= 1'b0;
        end else if (start_ok) begin
            sent_cnt <= '0;
            rcvd_cnt <= '0;
            mismatch <= 1'b0;
        end else begin
            sent_cnt <= sent_n;
            rcvd_cnt <= rcvd_n;
            if (done_n) mismatch <= (sent_n != rcvd_n);
        end
    end
`endif

endmodule

// File: doc/switch_host_master.md
Name: switch_host_master

Overview:
- Avalon-MM style bus initiator that drives the fixed-length switch's host register port. It is the other end of the switch's register interface.
- Accepts ingress descriptors from a harness, writes them into the per-port ingress queues, starts an experiment, runs it for a programmed cycle count, stops it, then drains egress metadata by polling reads.
- Sits between the on-chip test harness/HPS bridge and the switch top.

Parameters:
- NUM_PORTS, 4, switch ports. Ingress data addresses are 1..NUM_PORTS.
- RUN_CYCLES_W, 16, width of the run-length counter.
- MAX_DRAIN, 64, maximum polling reads in DRAIN before forced completion.
- DESC_DEPTH, 8, internal descriptor FIFO depth (power of 2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a session when in IDLE.
- run_cycles  in  RUN_CYCLES_W  experiment length; sampled on start.
- desc_valid  in  1  descriptor offered.
- desc_ready  out  1  FIFO not full.
- desc_port  in  2  destination ingress port.
- desc_data  in  32  ingress metadata word.
- av_address  out  3  switch register address.
- av_writedata  out  32  write data.
- av_write  out  1  write strobe.
- av_read  out  1  read strobe.
- av_chipselect  out  1  asserted with every write or read.
- av_readdata  in  32  switch read data, valid exactly 1 cycle after av_read.
- rx_valid  out  1  one-cycle pulse; drained egress word.
- rx_data  out  32  drained word, with bit 31 cleared.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on entering IDLE from DRAIN.

Behaviour:
- Switch register map:
  - addr 0 CTRL: write 1 = experimenting on, write 0 = off.
  - addr 1..4: ingress metadata for port 0..3.
  - addr 5: egress read. Bit 31 = valid, bits 30:0 = metadata.
  - addr 6/7: reserved, never accessed.
- Reset values: all av_* outputs 0, rx_valid 0, rx_data 0, busy 0, done 0. desc_ready is 1 (FIFO empty). FSM is in IDLE, counters are 0, FIFO is empty.
- The descriptor FIFO accepts on desc_valid && desc_ready in any state, including during a session.
- Bus rules:
  - At most one of av_write/av_read per cycle, each with av_chipselect.
  - Every access lasts exactly one cycle; there is no waitrequest.
  - Outputs are registered.
- FSM states:
  - IDLE: start && FIFO non-empty → LOAD. start && FIFO empty → START_X. start is ignored outside IDLE.
  - LOAD: one write per cycle while the FIFO is non-empty. av_address = desc_port+1, av_writedata = desc_data, then pop. FIFO empty → START_X. Descriptors pushed during LOAD are also sent.
  - START_X: one write to addr 0 with data 1 → RUN. The run counter loads run_cycles.
  - RUN: the counter decrements each cycle. It exits to STOP on the cycle the count is 0, so run_cycles=0 spends exactly 1 cycle in RUN. Wrap-around is impossible.
  - STOP: one write to addr 0 with data 0 → DRAIN.
  - DRAIN: alternates issue (av_read, addr 5) and capture (sample av_readdata the next cycle).
    - Captured bit31=1: rx_valid pulses with the word, bit31 cleared; issue again.
    - Captured bit31=0, or MAX_DRAIN reads issued: → IDLE with done.
    - One read is outstanding at most.
- reset_n low mid-session: immediate return to IDLE. The FIFO is flushed and outputs take reset values. No CTRL=0 write is issued; the switch's own reset covers it.
- A simultaneous push and pop on a full FIFO is allowed: the pop frees a slot in the same cycle, and desc_ready is combinational from the count and the pop.

Optional Feature:
- Macro SWITCH_HOST_MASTER_CHECK_EN.
- When defined, adds:
  - Outputs sent_cnt[15:0] and rcvd_cnt[15:0], saturating at 0xFFFF and cleared on start.
  - Output mismatch, set at done when sent_cnt != rcvd_cnt and held until the next start.
- When undefined, these ports and their logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package switch_pkg holds:
  - Register address constants ADDR_CTRL, ADDR_INGRESS_BASE, ADDR_EGRESS.
  - EGRESS_VALID_BIT = 31.
  - The host_state_t enum {IDLE, LOAD, START_X, RUN, STOP, DRAIN}.
- Sub-module host_desc_fifo is a synchronous FIFO, DESC_DEPTH × 34 bits (port+data), providing full/empty/count.

Test Plan:
- Reset mid-LOAD with 3 descriptors queued → av_* outputs 0 and busy 0 next cycle; desc_ready=1; no further bus activity.
- Push 2 descriptors ({port 2, 0x0000_00AA}, {port 0, 0x0000_0055}), then start with run_cycles=5:
  - Writes in order: addr 3/0xAA, addr 1/0x55, addr 0/1.
  - busy held, then exactly 6 idle bus cycles, then addr 0/0.
- In DRAIN, readdata responses 0x8000_0011, 0x8000_0022, 0x0000_0000 → rx_data 0x11 then 0x22, three reads issued, done pulses once.
- Readdata always has bit31=1 → exactly 64 reads issued, then done.
- Start with FIFO empty and run_cycles=0 → CTRL=1 write, 1 RUN cycle, CTRL=0 write; start pulsed during RUN has no effect.
- With SWITCH_HOST_MASTER_CHECK_EN, 3 sent and 2 received → mismatch=1 at done; the next start clears it.
